// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: FSM states, default bus addresses, status bit map.
// Optional macro UART_TX_PARITY_EN adds an even-parity state to the transmit frame.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;
    localparam logic PARITY_CAP = 1'b1;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_t;
    localparam logic PARITY_CAP = 1'b0;
`endif

    localparam logic [15:0] UART_DATA_ADDR = 16'h2002;
    localparam logic [15:0] UART_STAT_ADDR = 16'h2004;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_PAR_BIT   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; full/empty derive from the count. Shared by UART TX and RX.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage carries no reset; only pointers and count define validity, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: non-blocking assignments let the pop read the old head while a push lands in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tridrive.sv
// Tristate bus driver: presents i_data on the shared bus while i_oe is high, releases it otherwise.
module tridrive #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_oe,
    inout  wire  [WIDTH-1:0] io_bus
);

    assign io_bus = i_oe ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus writes fill a FIFO that is serialized on txd, LSB first.
// Define UART_TX_PARITY_EN for an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 4,
    parameter logic [15:0] DATA_ADDR    = UART_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR    = UART_STAT_ADDR
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic [15:0] memAddr,
    inout  wire  [15:0] dataBus,
    input  logic        re_L,
    input  logic        we_L,
    output logic        txd,
    output logic        txBusy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t         r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_ovf;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic                w_wr_hit;
    logic                w_rd_hit;
    logic                w_fifo_pop;
    logic [7:0]          w_fifo_data;
    logic                w_full;
    logic                w_empty;
    logic [$clog2(DEPTH):0] w_fifo_count_unused;
    logic                w_ovf_evt;
    logic                w_baud_done;
    logic                w_frame_end;
    logic [15:0]         w_status;
    logic                w_unused_bus_hi;

    assign w_wr_hit        = !we_L && (memAddr == DATA_ADDR);
    assign w_rd_hit        = !re_L && (memAddr == STAT_ADDR);
    assign w_unused_bus_hi = ^dataBus[15:8];

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_frame_end = (r_state == STOP) && w_baud_done;
    // Popping straight out of the last stop cycle keeps back-to-back frames gapless.
    assign w_fifo_pop  = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign w_ovf_evt   = w_wr_hit && w_full && !w_fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_L),
        .i_push  (w_wr_hit),
        .i_data  (dataBus[7:0]),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count_unused)
    );

    // Sticky overflow; a same-cycle overflow beats the clear-on-read.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (w_rd_hit) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_fifo_pop) begin
            r_state  <= START;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_fifo_data;
`endif
        end else begin
            case (r_state)
                START: begin
                    r_baud <= w_baud_done ? '0 : r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_baud <= w_baud_done ? '0 : r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_baud <= w_baud_done ? '0 : r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_baud <= w_baud_done ? '0 : r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        txd = 1'b1;
        case (r_state)
            START:   txd = 1'b0;
            DATA:    txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd = r_parity;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign txBusy = (r_state != IDLE);

    always_comb begin
        w_status                 = '0;
        w_status[STAT_BUSY_BIT]  = txBusy;
        w_status[STAT_EMPTY_BIT] = w_empty;
        w_status[STAT_FULL_BIT]  = w_full;
        w_status[STAT_OVF_BIT]   = r_ovf;
        w_status[STAT_PAR_BIT]   = PARITY_CAP;
    end

    tridrive #(
        .WIDTH (16)
    ) u_bus_drv (
        .i_data (w_status),
        .i_oe   (w_rd_hit),
        .io_bus (dataBus)
    );

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus writes feed an expected-byte queue that a serial monitor drains.
// Builds with or without UART_TX_PARITY_EN.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [15:0] A_DATA = 16'h2002;
    localparam logic [15:0] A_STAT = 16'h2004;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [15:0] CAP = 16'h0010;
`else
    localparam int NBITS = 10;
    localparam logic [15:0] CAP = 16'h0000;
`endif
    localparam int F = NBITS * CPB;

    logic        clock   = 1'b0;
    logic        reset_L = 1'b0;
    logic [15:0] memAddr = 16'h0000;
    logic        re_L    = 1'b1;
    logic        we_L    = 1'b1;
    logic        tb_drv  = 1'b0;
    logic [15:0] tb_val  = 16'h0000;
    wire  [15:0] dataBus;
    logic        txd;
    logic        txBusy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_frames = 0;
    logic [7:0] q_exp[$];
    int         q_start[$];

    assign dataBus = tb_drv ? tb_val : 16'hzzzz;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .DATA_ADDR    (A_DATA),
        .STAT_ADDR    (A_STAT)
    ) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .memAddr (memAddr),
        .dataBus (dataBus),
        .re_L    (re_L),
        .we_L    (we_L),
        .txd     (txd),
        .txBusy  (txBusy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [15:0] v);
        memAddr = A_DATA;
        tb_val  = v;
        tb_drv  = 1'b1;
        we_L    = 1'b0;
        @(posedge clock);
        #1;
        we_L    = 1'b1;
        tb_drv  = 1'b0;
        memAddr = 16'h0000;
    endtask

    task automatic stat_read(input string name, input logic [15:0] exp);
        memAddr = A_STAT;
        re_L    = 1'b0;
        #1;
        check(name, dataBus, exp);
        @(posedge clock);
        #1;
        re_L    = 1'b1;
        memAddr = 16'h0000;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (txBusy && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    // Walks one frame cycle by cycle; call right after the write that makes the FIFO non-empty.
    task automatic check_frame(input string name, input logic [7:0] b);
        logic [10:0] fb;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, ^b, b, 1'b0};
`else
        fb = {1'b1, 1'b1, b, 1'b0};
`endif
        check({name, "_pre_pop"}, {txBusy, txd}, 2'b01);
        for (int c = 0; c < F; c++) begin
            @(posedge clock);
            #1;
            check({name, "_wave"}, {txBusy, txd}, {1'b1, fb[c / CPB]});
        end
        @(posedge clock);
        #1;
        check({name, "_post"}, {txBusy, txd}, 2'b01);
    endtask

    // Serial monitor: finds a start bit, samples mid-bit, compares against the expected-byte queue.
    initial begin : monitor
        logic       active;
        int         off;
        int         idx;
        logic [7:0] rx;
        active = 1'b0;
        off    = 0;
        rx     = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset_L) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd === 1'b0) begin
                    active = 1'b1;
                    off    = 0;
                    q_start.push_back(cyc);
                    n_frames++;
                end
            end else begin
                off++;
                if (off % CPB == CPB / 2) begin
                    idx = off / CPB;
                    if (idx == 0) begin
                        check("mon_start_bit", txd, 1'b0);
                    end else if (idx <= 8) begin
                        rx[idx - 1] = txd;
`ifdef UART_TX_PARITY_EN
                    end else if (idx == 9) begin
                        check("mon_parity_bit", txd, ^rx);
`endif
                    end else begin
                        check("mon_stop_bit", {txBusy, txd}, 2'b11);
                        check("mon_frame_expected", q_exp.size() != 0, 1'b1);
                        if (q_exp.size() != 0) begin
                            check("mon_rx_byte", rx, q_exp.pop_front());
                        end
                    end
                end
                if (off == F - 1) begin
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int nf;

        // Reset and idle
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {txBusy, txd}, 2'b01);
        reset_L = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("idle_outputs", {txBusy, txd}, 2'b01);
        stat_read("idle_status", 16'h0002 | CAP);

        // Single frame, upper byte ignored
        bus_write(16'hAB55);
        q_exp.push_back(8'h55);
        check_frame("ab55", 8'h55);

        // Three back-to-back frames
        q_start.delete();
        bus_write(16'h0001);
        q_exp.push_back(8'h01);
        bus_write(16'h0002);
        q_exp.push_back(8'h02);
        bus_write(16'h0003);
        q_exp.push_back(8'h03);
        stat_read("b2b_stat_two_queued", 16'h0001 | CAP);
        repeat (2 * F - 3) begin
            @(posedge clock);
            #1;
        end
        stat_read("b2b_stat_before_pop3", 16'h0001 | CAP);
        stat_read("b2b_stat_after_pop3", 16'h0003 | CAP);
        wait_idle(4 * F, n);
        check("b2b_busy_tail", n, F - 1);
        check("b2b_frame_count", q_start.size(), 3);
        if (q_start.size() == 3) begin
            check("b2b_gap_1_2", q_start[1] - q_start[0], F);
            check("b2b_gap_2_3", q_start[2] - q_start[1], F);
        end

        // Overflow: six writes into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            bus_write(16'h0010 + 16'(i));
            if (i < 5) q_exp.push_back(8'h10 + 8'(i));
        end
        stat_read("ovf_status", 16'h000D | CAP);
        stat_read("ovf_cleared", 16'h0005 | CAP);
        repeat (F - 7) begin
            @(posedge clock);
            #1;
        end
        bus_write(16'h0016);
        q_exp.push_back(8'h16);
        stat_read("full_push_pop_no_ovf", 16'h0005 | CAP);
        wait_idle(8 * F, n);
        check("ovf_drained_idle", txBusy, 1'b0);
        stat_read("ovf_final_status", 16'h0002 | CAP);
        check("ovf_scoreboard_empty", q_exp.size(), 0);

        // Reset in the middle of a frame with two bytes queued
        bus_write(16'h0021);
        bus_write(16'h0022);
        bus_write(16'h0023);
        repeat (3 * CPB) begin
            @(posedge clock);
            #1;
        end
        check("rst_pre_busy", txBusy, 1'b1);
        nf = n_frames;
        reset_L = 1'b0;
        #1;
        check("rst_txd_idle", {txBusy, txd}, 2'b01);
        stat_read("rst_stat_empty", 16'h0002 | CAP);
        reset_L = 1'b1;
        repeat (3 * F) begin
            @(posedge clock);
            #1;
        end
        check("rst_no_new_frames", n_frames, nf);
        check("rst_txd_high", {txBusy, txd}, 2'b01);
        stat_read("rst_stat_after", 16'h0002 | CAP);

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has three ones
        bus_write(16'h0007);
        q_exp.push_back(8'h07);
        check_frame("par07", 8'h07);
`endif

        repeat (4) @(posedge clock);
        #1;
        check("final_scoreboard_empty", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
